m_win_judge: RTL and testbench



---
 rtl/m_win_judge_pkg.sv | 31 +++
 rtl/m_win_judge_line.sv | 35 +++
 rtl/m_win_judge.sv | 116 +++++++++++
 tb/tb_m_win_judge.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/m_win_judge_pkg.sv
// Shared board geometry, result encodings and FSM states for the four-in-a-row judge.
package m_win_judge_pkg;

    localparam int COL_COUNT  = 7;
    localparam int ROW_COUNT  = 6;
    localparam int WIN_LEN    = 4;
    localparam int FIELD_SIZE = COL_COUNT * ROW_COUNT;

    // Anchor bounds for each window direction, sized to the col/row counters.
    localparam logic [2:0] H_MAX_COL  = 3'(COL_COUNT - WIN_LEN);
    localparam logic [2:0] V_MAX_ROW  = 3'(ROW_COUNT - WIN_LEN);
    localparam logic [2:0] DN_MIN_ROW = 3'(WIN_LEN - 1);
    localparam logic [2:0] LAST_ROW   = 3'(ROW_COUNT - 1);
    localparam logic [5:0] LAST_CELL  = 6'(FIELD_SIZE - 1);

    localparam logic [1:0] RES_NONE = 2'b00;
    localparam logic [1:0] RES_YOU  = 2'b01;
    localparam logic [1:0] RES_AI   = 2'b10;
    localparam logic [1:0] RES_BOTH = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DONE
    } state_t;

    function automatic logic [5:0] cell_idx(input logic [2:0] col, input logic [2:0] row);
        return 6'(col) * 6'(ROW_COUNT) + 6'(row);
    endfunction

endpackage

// File: rtl/m_win_judge_line.sv
// Combinational window checker: for one anchor cell, builds the H, V, D+ and D- masks
// and flags which of them are fully covered by the given field.
module m_line_checker
    import m_win_judge_pkg::*;
(
    input  logic [FIELD_SIZE-1:0]      field,
    input  logic [2:0]                 col,
    input  logic [2:0]                 row,
    output logic [3:0]                 hit,
    output logic [3:0][FIELD_SIZE-1:0] mask
);

    logic [3:0] ok;

    assign ok[0] = (col <= H_MAX_COL);
    assign ok[1] = (row <= V_MAX_ROW);
    assign ok[2] = ok[0] && ok[1];
    assign ok[3] = ok[0] && (row >= DN_MIN_ROW);

    // Masks are only built for in-bounds windows, so the 3-bit offsets never wrap.
    always_comb begin
        mask = '0;
        hit  = '0;
        for (int i = 0; i < WIN_LEN; i++) begin
            if (ok[0]) mask[0][cell_idx(col + 3'(i), row)]          = 1'b1;
            if (ok[1]) mask[1][cell_idx(col, row + 3'(i))]          = 1'b1;
            if (ok[2]) mask[2][cell_idx(col + 3'(i), row + 3'(i))]  = 1'b1;
            if (ok[3]) mask[3][cell_idx(col + 3'(i), row - 3'(i))]  = 1'b1;
        end
        for (int d = 0; d < 4; d++) begin
            hit[d] = ok[d] && ((field & mask[d]) == mask[d]);
        end
    end

endmodule

// File: rtl/m_win_judge.sv
// Sequential four-in-a-row judge: snapshots both fields on start, scans one anchor
// per cycle for 42 cycles, then pulses done with result, draw flag and first winning line.
module m_win_judge
    import m_win_judge_pkg::*;
(
    input  logic                  w_clk,
    input  logic                  w_rst,
    input  logic                  i_start,
    input  logic [FIELD_SIZE-1:0] i_your_field,
    input  logic [FIELD_SIZE-1:0] i_ai_field,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [1:0]            o_result,
    output logic                  o_draw,
    output logic [FIELD_SIZE-1:0] o_win_line
);

    state_t                      state, state_nxt;
    logic [5:0]                  cnt;
    logic [2:0]                  col, row;
    logic [FIELD_SIZE-1:0]       snap_you, snap_ai;
    logic [1:0]                  result_q, result_nxt;
    logic                        draw_q;
    logic [FIELD_SIZE-1:0]       line_q, hit_line;
    logic [3:0]                  you_hit, ai_hit;
    logic [3:0][FIELD_SIZE-1:0]  you_mask, ai_mask;

    m_line_checker u_you (
        .field (snap_you),
        .col   (col),
        .row   (row),
        .hit   (you_hit),
        .mask  (you_mask)
    );

    m_line_checker u_ai (
        .field (snap_ai),
        .col   (col),
        .row   (row),
        .hit   (ai_hit),
        .mask  (ai_mask)
    );

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        o_busy    = 1'b0;
        o_done    = 1'b0;
        case (state)
            ST_IDLE: if (i_start) state_nxt = ST_SCAN;
            ST_SCAN: begin
                o_busy = 1'b1;
                if (cnt == LAST_CELL) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                o_done    = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Walking downwards lets lower directions overwrite, and the human overwrite the AI.
    always_comb begin
        hit_line = '0;
        for (int d = 3; d >= 0; d--) begin
            if (ai_hit[d])  hit_line = ai_mask[d];
            if (you_hit[d]) hit_line = you_mask[d];
        end
    end

    assign result_nxt = result_q | {|ai_hit, |you_hit};

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            cnt      <= '0;
            col      <= '0;
            row      <= '0;
            snap_you <= '0;
            snap_ai  <= '0;
            result_q <= RES_NONE;
            draw_q   <= 1'b0;
            line_q   <= '0;
        end else if (state == ST_IDLE && i_start) begin
            cnt      <= '0;
            col      <= '0;
            row      <= '0;
            snap_you <= i_your_field;
            snap_ai  <= i_ai_field;
            result_q <= RES_NONE;
            draw_q   <= 1'b0;
            line_q   <= '0;
        end else if (state == ST_SCAN) begin
            result_q <= result_nxt;
            if (line_q == '0) line_q <= hit_line;
            cnt <= cnt + 6'd1;
            if (row == LAST_ROW) begin
                row <= '0;
                col <= col + 3'd1;
            end else begin
                row <= row + 3'd1;
            end
            if (cnt == LAST_CELL)
                draw_q <= (result_nxt == RES_NONE) && (&(snap_you | snap_ai));
        end
    end

    assign o_result   = result_q;
    assign o_draw     = draw_q;
    assign o_win_line = line_q;

endmodule

// File: tb/tb_m_win_judge.sv
// Scoreboard bench for m_win_judge: directed boards push expected results, a monitor checks each done pulse.
module tb_m_win_judge;

    logic        w_clk = 1'b0;
    logic        w_rst = 1'b1;
    logic        i_start = 1'b0;
    logic [41:0] i_your_field = '0;
    logic [41:0] i_ai_field = '0;
    logic        o_busy, o_done, o_draw;
    logic [1:0]  o_result;
    logic [41:0] o_win_line;

    always #5 w_clk = ~w_clk;

    m_win_judge dut (
        .w_clk        (w_clk),
        .w_rst        (w_rst),
        .i_start      (i_start),
        .i_your_field (i_your_field),
        .i_ai_field   (i_ai_field),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_result     (o_result),
        .o_draw       (o_draw),
        .o_win_line   (o_win_line)
    );

    typedef struct {
        logic [1:0]  res;
        logic        draw;
        logic [41:0] line;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   done_cnt = 0;

    always @(posedge w_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge w_clk) begin
        if (o_done === 1'b1) begin
            exp_t e;
            done_cnt++;
            if (sb.size() == 0) begin
                fail("unexpected_done");
            end else begin
                e = sb.pop_front();
                chk("latency", 64'(cyc), 64'(e.due));
                chk("result", 64'(o_result), 64'(e.res));
                chk("draw", 64'(o_draw), 64'(e.draw));
                chk("win_line", 64'(o_win_line), 64'(e.line));
                chk("busy_at_done", 64'(o_busy), 64'd0);
            end
        end
    end

    task automatic start_scan(input logic [41:0] y, input logic [41:0] a, input bit expect_done,
                              input logic [1:0] res, input logic draw, input logic [41:0] line);
        exp_t e;
        @(negedge w_clk);
        i_your_field = y;
        i_ai_field   = a;
        i_start      = 1'b1;
        if (expect_done) begin
            e.res  = res;
            e.draw = draw;
            e.line = line;
            e.due  = cyc + 43;
            sb.push_back(e);
        end
        @(negedge w_clk);
        i_start = 1'b0;
        chk("busy_after_start", 64'(o_busy), 64'd1);
    endtask

    task automatic wait_done(input int budget);
        int base;
        int n;
        base = done_cnt;
        n = 0;
        while (done_cnt == base && n < budget) begin
            @(negedge w_clk);
            n++;
        end
        if (done_cnt == base) fail("done_timeout");
    endtask

    task automatic run(input logic [41:0] y, input logic [41:0] a,
                       input logic [1:0] res, input logic draw, input logic [41:0] line);
        start_scan(y, a, 1'b1, res, draw, line);
        wait_done(60);
        repeat (3) @(negedge w_clk);
        chk("hold_result", 64'(o_result), 64'(res));
        chk("hold_line", 64'(o_win_line), 64'(line));
    endtask

    logic [41:0] draw_you, draw_ai, top_bit;

    initial begin
        repeat (3) @(negedge w_clk);
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_done", 64'(o_done), 64'd0);
        chk("rst_result", 64'(o_result), 64'd0);
        chk("rst_draw", 64'(o_draw), 64'd0);
        chk("rst_line", 64'(o_win_line), 64'd0);
        w_rst = 1'b0;

        run(42'h0, 42'h0, 2'b00, 1'b0, 42'h0);

        // Bottom-row human line; fields change and a second start arrives mid-scan.
        start_scan(42'h41041, 42'h0, 1'b1, 2'b01, 1'b0, 42'h41041);
        repeat (2) @(negedge w_clk);
        i_your_field = '0;
        i_ai_field   = '1;
        repeat (2) @(negedge w_clk);
        i_start = 1'b1;
        @(negedge w_clk);
        i_start = 1'b0;
        wait_done(60);
        repeat (3) @(negedge w_clk);

        run(42'h0, 42'h3C000000000, 2'b10, 1'b0, 42'h3C000000000);
        run(42'h204081, 42'hF000000, 2'b11, 1'b0, 42'h204081);
        run(42'h41041, 42'hF, 2'b11, 1'b0, 42'h41041);
        run(42'h20820800000, 42'h0, 2'b01, 1'b0, 42'h20820800000);
        run(42'h0, 42'h42108, 2'b10, 1'b0, 42'h42108);
        run(42'hF0, 42'h0, 2'b00, 1'b0, 42'h0);

        // Column-pair checkerboard: full board with no four for either side.
        draw_you = '0;
        draw_ai  = '0;
        for (int c = 0; c < 7; c++) begin
            for (int r = 0; r < 6; r++) begin
                if ((((c >> 1) + r) % 2) == 0) draw_you[c * 6 + r] = 1'b1;
                else                           draw_ai[c * 6 + r]  = 1'b1;
            end
        end
        run(draw_you, draw_ai, 2'b00, 1'b1, 42'h0);
        top_bit = '0;
        top_bit[41] = 1'b1;
        run(draw_you & ~top_bit, draw_ai & ~top_bit, 2'b00, 1'b0, 42'h0);

        // Reset in the middle of a winning scan, with an ignored restart before it.
        start_scan(42'h41041, 42'h0, 1'b0, 2'b00, 1'b0, 42'h0);
        repeat (3) @(negedge w_clk);
        i_start = 1'b1;
        @(negedge w_clk);
        i_start = 1'b0;
        repeat (5) @(negedge w_clk);
        w_rst = 1'b1;
        #1;
        chk("midrst_busy", 64'(o_busy), 64'd0);
        chk("midrst_done", 64'(o_done), 64'd0);
        chk("midrst_result", 64'(o_result), 64'd0);
        chk("midrst_draw", 64'(o_draw), 64'd0);
        chk("midrst_line", 64'(o_win_line), 64'd0);
        @(negedge w_clk);
        w_rst = 1'b0;
        repeat (50) @(negedge w_clk);
        chk("post_rst_busy", 64'(o_busy), 64'd0);
        chk("post_rst_sb_empty", 64'(sb.size()), 64'd0);

        run(42'h41041, 42'h0, 2'b01, 1'b0, 42'h41041);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

endmodule
